wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Writeback arbiter that collects register results from two producers, the ALU path (source 0) and the load path (source 1), and drives the single register-file write port. Each source has a small FIFO behind a valid/ready handshake. At most one register write is issued per cycle, so neither producer has to stall on a write-port conflict unless its FIFO is full. The block sits between the execute/memory stages and the register file. Its outputs connect directly to the register file's we/waddr/wdata inputs.

## Interface
- DEPTH, 2, entries per source FIFO; power of two, minimum 2
- AW, 5, register address width
- DW, 32, data width
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low
- s0_valid  in  1  ALU result valid
- s0_ready  out  1  source-0 FIFO can accept
- s0_addr  in  AW  destination register
- s0_data  in  DW  result value
- s1_valid  in  1  load result valid
- s1_ready  out  1  source-1 FIFO can accept
- s1_addr  in  AW  destination register
- s1_data  in  DW  result value
- we  out  1  register-file write enable (registered)
- waddr  out  AW  register-file write address (registered)
- wdata  out  DW  register-file write data (registered)
- busy  out  1  any FIFO non-empty, or we high

## Operation
- Each source has its own DEPTH-entry circular FIFO.
  - Read and write pointers are log2(DEPTH)+1 bits, with the MSB used as the wrap bit.
  - full = pointers equal except for the MSB.
  - empty = pointers fully equal.
- Push:
  - sN_ready = !fullN; it is derived from registered state only, with no path from sN_valid.
  - A push occurs on an edge where sN_valid && sN_ready.
  - A full FIFO refuses a push even if it pops on the same edge.
- Arbitration (combinational, from the FIFO heads):
  - If only one FIFO is non-empty, that FIFO is granted.
  - If both are non-empty, see Configuration.
  - If neither is non-empty, there is no grant.
- Grant on source N:
  - Pop head N on the edge.
  - Register waddr <= head addr and wdata <= head data.
  - Register we <= (head addr != 0).
  - A write to x0 is consumed but never issued.
- No grant: we <= 0; waddr and wdata hold their previous values.
- Simultaneous push and pop on the same FIFO are both honoured; the count is unchanged.
- Per-source ordering is strict FIFO. No ordering between sources is guaranteed.
- busy = !empty0 || !empty1 || we.

## Timing
- Reset values: we=0, waddr=0, wdata=0, both FIFOs empty, s0_ready=s1_ready=1, busy=0, last_grant=1.
- Reset asserted mid-operation:
  - Takes effect immediately and asynchronously.
  - All FIFO contents are discarded.
  - we drops to 0 without waiting for a clock edge.
- Latency with no contention:
  - Handshake accepted in cycle 0.
  - Entry is at the FIFO head in cycle 1.
  - we/waddr/wdata are valid in cycle 2.
  - The register file captures the write at the end of cycle 2.
- Throughput: one write per cycle in aggregate. With both FIFOs kept busy, each source gets at least one grant every two cycles (round-robin mode).
- A source can push every cycle while its FIFO is not full.
- A sustained one-per-cycle push with no grants fills the FIFO in DEPTH cycles. sN_ready is low from the following cycle.

## Configuration
- WB_RR_EN defined (round-robin):
  - When both FIFOs are non-empty, the source not granted last is granted.
  - last_grant updates on every grant, including dropped x0 writes.
  - It resets to 1, so source 0 wins the first tie.
- WB_RR_EN undefined (fixed priority):
  - Source 1 (load) always wins ties.
  - The last_grant register is not implemented.
  - Source 0 can be starved for as long as source 1 stays non-empty.

## Test plan
- Single write: s0 pushes addr=5, data=0xDEADBEEF in cycle 0 -> we=1, waddr=5, wdata=0xDEADBEEF in cycle 2 only; busy high in cycles 1–2, then low.
- x0 drop: s1 pushes addr=0, data=0x1234 -> FIFO empties in cycle 1, we stays 0 throughout, s1_ready stays 1.
- Tie with WB_RR_EN: both sources push in cycle 0 (s0 addr=1/data=0x11, s1 addr=2/data=0x22) -> cycle 2: waddr=1, wdata=0x11; cycle 3: waddr=2, wdata=0x22.
- Same stimulus without WB_RR_EN -> cycle 2: waddr=2; cycle 3: waddr=1. Also hold s1 non-empty for 10 cycles -> no s0 write is issued during that window.
- Backpressure, DEPTH=2, WB_RR_EN:
  - Stimulus: s1 pushes every cycle; s0 pushes 4 entries (addr 1–4) back to back.
  - s0_ready goes low once the s0 FIFO holds 2 entries.
  - Every accepted entry is eventually written exactly once, in per-source order; s0 writes issue with waddr=1,2,3,4 in that order.
  - No entry is lost or duplicated.
- Reset mid-operation: fill both FIFOs, then assert rst for one cycle -> we=0 immediately, busy=0, both ready=1. After release, no stale entries are written.

Source files
------------

// File: rtl/wb_arbiter.sv
// ============================================================================
// Module   : wb_arbiter
// Purpose  : Two-source writeback arbiter: per-source FIFOs feeding a single
//            registered register-file write port. Define WB_RR_EN for
//            round-robin tie-breaking (default: load path has fixed priority).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s0_valid,
  output logic          s0_ready,
  input  logic [AW-1:0] s0_addr,
  input  logic [DW-1:0] s0_data,
  input  logic          s1_valid,
  output logic          s1_ready,
  input  logic [AW-1:0] s1_addr,
  input  logic [DW-1:0] s1_data,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] wdata,
  output logic          busy
);

  localparam int c_pw = $clog2(DEPTH);

  logic [1:0]    w_valid;
  logic [1:0]    w_ready;
  logic [1:0]    w_nempty;
  logic [1:0]    w_pop;
  logic [AW-1:0] w_in_addr   [2];
  logic [DW-1:0] w_in_data   [2];
  logic [AW-1:0] w_head_addr [2];
  logic [DW-1:0] w_head_data [2];

  assign w_valid      = {s1_valid, s0_valid};
  assign w_in_addr[0] = s0_addr;
  assign w_in_addr[1] = s1_addr;
  assign w_in_data[0] = s0_data;
  assign w_in_data[1] = s1_data;
  assign s0_ready     = w_ready[0];
  assign s1_ready     = w_ready[1];

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    localparam logic [c_pw:0] c_ptr_one = (c_pw + 1)'(1);

    logic [c_pw:0]  wp_q, wp_d, rp_q, rp_d;
    logic [AW-1:0]  mem_addr_q [DEPTH];
    logic [DW-1:0]  mem_data_q [DEPTH];
    logic           w_full;
    logic           w_push;

    // Full is judged on registered pointers only, so a same-edge pop cannot free a slot.
    assign w_full  = (wp_q[c_pw] != rp_q[c_pw]) && (wp_q[c_pw-1:0] == rp_q[c_pw-1:0]);
    assign w_push  = w_valid[g] && !w_full;
    assign wp_d    = w_push   ? wp_q + c_ptr_one : wp_q;
    assign rp_d    = w_pop[g] ? rp_q + c_ptr_one : rp_q;

    assign w_ready[g]     = !w_full;
    assign w_nempty[g]    = (wp_q != rp_q);
    assign w_head_addr[g] = mem_addr_q[rp_q[c_pw-1:0]];
    assign w_head_data[g] = mem_data_q[rp_q[c_pw-1:0]];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        wp_q <= '0;
        rp_q <= '0;
      end else begin
        wp_q <= wp_d;
        rp_q <= rp_d;
      end
    end

    always_ff @(posedge clk) begin
      if (w_push) begin
        mem_addr_q[wp_q[c_pw-1:0]] <= w_in_addr[g];
        mem_data_q[wp_q[c_pw-1:0]] <= w_in_data[g];
      end
    end
  end

  logic w_gnt;
  logic w_sel;
  logic w_tie_sel;

`ifdef WB_RR_EN
  logic last_grant_q;

  assign w_tie_sel = ~last_grant_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       last_grant_q <= 1'b1;
    else if (w_gnt) last_grant_q <= w_sel;
  end
`else
  assign w_tie_sel = 1'b1;
`endif

  always_comb begin
    w_gnt = |w_nempty;
    w_sel = w_nempty[1];
    if (w_nempty == 2'b11) w_sel = w_tie_sel;
    w_pop = 2'b00;
    if (w_gnt) w_pop = w_sel ? 2'b10 : 2'b01;
  end

  logic          we_q,    we_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  // x0 entries are popped and recorded but never raise we.
  always_comb begin
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (w_gnt) begin
      we_d    = (w_head_addr[w_sel] != '0);
      waddr_d = w_head_addr[w_sel];
      wdata_d = w_head_data[w_sel];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign we    = we_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;
  assign busy  = (|w_nempty) || we_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
// ============================================================================
// Module   : tb_wb_arbiter
// Purpose  : Directed self-checking bench for wb_arbiter (either WB_RR_EN mode).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_wb_arbiter;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 2;

`ifdef WB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          s0_valid = 1'b0, s1_valid = 1'b0;
  logic          s0_ready, s1_ready;
  logic [AW-1:0] s0_addr = '0, s1_addr = '0;
  logic [DW-1:0] s0_data = '0, s1_data = '0;
  logic          we, busy;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;

  int errors = 0;
  int checks = 0;

  wb_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_addr(s0_addr), .s0_data(s0_data),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_addr(s1_addr), .s1_data(s1_data),
    .we(we), .waddr(waddr), .wdata(wdata), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [AW+DW-1:0] exp0 [$];
  logic [AW+DW-1:0] exp1 [$];

  initial begin
    int  s0_wr;
    int  n0, n1, wr0, wr1, late_wr;
    bit  saw_low, acc0, acc1;
    logic [AW+DW-1:0] e;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    chk("rst_we",     64'(we),       64'd0);
    chk("rst_waddr",  64'(waddr),    64'd0);
    chk("rst_wdata",  64'(wdata),    64'd0);
    chk("rst_ready0", 64'(s0_ready), 64'd1);
    chk("rst_ready1", 64'(s1_ready), 64'd1);
    chk("rst_busy",   64'(busy),     64'd0);

    // Single write: accepted cycle 0, written in cycle 2 only.
    s0_valid = 1'b1; s0_addr = 5'd5; s0_data = 32'hDEADBEEF;
    step();
    s0_valid = 1'b0;
    chk("single_c1_we",   64'(we),   64'd0);
    chk("single_c1_busy", 64'(busy), 64'd1);
    step();
    chk("single_c2_we",    64'(we),    64'd1);
    chk("single_c2_waddr", 64'(waddr), 64'd5);
    chk("single_c2_wdata", 64'(wdata), 64'hDEADBEEF);
    chk("single_c2_busy",  64'(busy),  64'd1);
    step();
    chk("single_c3_we",   64'(we),   64'd0);
    chk("single_c3_busy", 64'(busy), 64'd0);
    chk("single_c3_hold", 64'(waddr), 64'd5);

    // x0 write is consumed without raising we.
    s1_valid = 1'b1; s1_addr = 5'd0; s1_data = 32'h1234;
    step();
    s1_valid = 1'b0;
    chk("x0_c1_we",    64'(we),       64'd0);
    chk("x0_c1_busy",  64'(busy),     64'd1);
    chk("x0_c1_ready", 64'(s1_ready), 64'd1);
    step();
    chk("x0_c2_we",    64'(we),       64'd0);
    chk("x0_c2_busy",  64'(busy),     64'd0);
    chk("x0_c2_ready", 64'(s1_ready), 64'd1);

    // Tie: last grant was source 1, so round-robin favours source 0.
    s0_valid = 1'b1; s0_addr = 5'd1; s0_data = 32'h11;
    s1_valid = 1'b1; s1_addr = 5'd2; s1_data = 32'h22;
    step();
    s0_valid = 1'b0; s1_valid = 1'b0;
    step();
    chk("tie_c2_we",    64'(we),    64'd1);
    chk("tie_c2_waddr", 64'(waddr), RR ? 64'd1 : 64'd2);
    chk("tie_c2_wdata", 64'(wdata), RR ? 64'h11 : 64'h22);
    step();
    chk("tie_c3_we",    64'(we),    64'd1);
    chk("tie_c3_waddr", 64'(waddr), RR ? 64'd2 : 64'd1);
    chk("tie_c3_wdata", 64'(wdata), RR ? 64'h22 : 64'h11);
    step();
    chk("tie_c4_busy", 64'(busy), 64'd0);

    // Keep source 1 non-empty for 10 cycles while source 0 holds one entry.
    s0_wr = 0;
    for (int i = 0; i < 10; i++) begin
      s0_valid = (i == 0); s0_addr = 5'd7; s0_data = 32'h77;
      s1_valid = 1'b1;     s1_addr = 5'd8; s1_data = 32'(i);
      step();
      if (we && waddr == 5'd7) s0_wr++;
    end
    s0_valid = 1'b0; s1_valid = 1'b0;
    chk("starve_window", 64'(s0_wr), RR ? 64'd1 : 64'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      if (we && waddr == 5'd7) s0_wr++;
    end
    chk("starve_total", 64'(s0_wr), 64'd1);
    chk("starve_busy",  64'(busy),  64'd0);

    // Backpressure with scoreboard: every accepted entry written once, in order.
    n0 = 0; n1 = 0; wr0 = 0; wr1 = 0; saw_low = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      s0_valid = (n0 < 4); s0_addr = 5'(n0 + 1);  s0_data = 32'hA000 + 32'(n0);
      s1_valid = (n1 < 6); s1_addr = 5'(n1 + 16); s1_data = 32'hB000 + 32'(n1);
      acc0 = s0_valid && s0_ready;
      acc1 = s1_valid && s1_ready;
      if (!s0_ready) saw_low = 1'b1;
      step();
      if (acc0) begin exp0.push_back({s0_addr, s0_data}); n0++; end
      if (acc1) begin exp1.push_back({s1_addr, s1_data}); n1++; end
      if (we) begin
        if (waddr < 5'd16) begin
          checks++;
          assert (exp0.size() != 0) else begin
            errors++;
            $error("FAIL bp_s0_extra: observed=waddr 0x%0h expected=no s0 write", waddr);
          end
          if (exp0.size() != 0) begin
            e = exp0.pop_front();
            chk("bp_s0_order", 64'({waddr, wdata}), 64'(e));
          end
          wr0++;
        end else begin
          checks++;
          assert (exp1.size() != 0) else begin
            errors++;
            $error("FAIL bp_s1_extra: observed=waddr 0x%0h expected=no s1 write", waddr);
          end
          if (exp1.size() != 0) begin
            e = exp1.pop_front();
            chk("bp_s1_order", 64'({waddr, wdata}), 64'(e));
          end
          wr1++;
        end
      end
    end
    s0_valid = 1'b0; s1_valid = 1'b0;
    chk("bp_s0_count",   64'(wr0),         64'd4);
    chk("bp_s1_count",   64'(wr1),         64'd6);
    chk("bp_s0_left",    64'(exp0.size()), 64'd0);
    chk("bp_s1_left",    64'(exp1.size()), 64'd0);
    chk("bp_ready_low",  64'(saw_low),     64'd1);
    chk("bp_busy",       64'(busy),        64'd0);

    // Reset mid-operation with both FIFOs loaded.
    for (int i = 0; i < 3; i++) begin
      s0_valid = 1'b1; s0_addr = 5'd3; s0_data = 32'h33 + 32'(i);
      s1_valid = 1'b1; s1_addr = 5'd4; s1_data = 32'h44 + 32'(i);
      step();
    end
    s0_valid = 1'b0; s1_valid = 1'b0;
    chk("prerst_we",   64'(we),   64'd1);
    chk("prerst_busy", 64'(busy), 64'd1);
    rst = 1'b0;
    #1;
    chk("midrst_we",     64'(we),       64'd0);
    chk("midrst_busy",   64'(busy),     64'd0);
    chk("midrst_ready0", 64'(s0_ready), 64'd1);
    chk("midrst_ready1", 64'(s1_ready), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    late_wr = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (we) late_wr++;
    end
    chk("postrst_writes", 64'(late_wr), 64'd0);
    chk("postrst_busy",   64'(busy),    64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
